shift_right_serial: RTL and testbench

- Multi-cycle iterative right shifter for the ALU execute stage: the right-shift counterpart of the combinational left-shift op.
- Implements RV32I SRL (logical) and SRA (arithmetic) on 32-bit operands.
- Shifts up to STEP bit positions per clock.
- Uses a valid/ready handshake on both input and output, so the ALU control can stall the pipeline around it.

---
 rtl/alu_pkg.sv | 41 ++++
 rtl/shr_step.sv | 29 ++
 rtl/shift_right_serial.sv | 118 +++++++++++
 tb/tb_shift_right_serial.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU definitions: operand width, shift-amount width, the serial
// right shifter's state encoding and the shift-op encoding used by the decoder.
package alu_pkg;

    localparam int XLEN    = 32;
    localparam int SHAMT_W = 5;
    // A single step may move up to 32 positions, so the step amount needs one
    // more bit than a shift amount.
    localparam int STEP_W  = SHAMT_W + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } shr_state_t;

    typedef enum logic {
        SHIFT_OP_SRL = 1'b0,
        SHIFT_OP_SRA = 1'b1
    } alu_shift_op_t;

    // Per-cycle step sizes that the iterative shifter is built for.
    function automatic logic step_is_legal(input int step);
        return (step == 1) || (step == 2) || (step == 4) ||
               (step == 8) || (step == 16) || (step == 32);
    endfunction

    // Positions to move this cycle: min(step, remaining).
    function automatic logic [STEP_W-1:0] shr_step_amount(
        input logic [SHAMT_W-1:0] remaining,
        input int                 step
    );
        logic [STEP_W-1:0] step_v;
        step_v = STEP_W'(step);
        if ({1'b0, remaining} < step_v) begin
            return {1'b0, remaining};
        end
        return step_v;
    endfunction

endpackage

// File: rtl/shr_step.sv
// One iteration of the serial right shifter: shifts data right by n positions
// (0..STEP) and fills the vacated upper bits with fill_i. Only STEP+1 shift
// distances are ever needed, so this is a narrow mux rather than a barrel shifter.
module shr_step
    import alu_pkg::*;
#(
    parameter int STEP = 1
)
(
    input  logic [XLEN-1:0]   data_i,
    input  logic [STEP_W-1:0] n_i,
    input  logic              fill_i,
    output logic [XLEN-1:0]   data_o
);

    logic [XLEN+STEP-1:0] ext;

    // Select data_i shifted by exactly n_i, taken from the fill-extended word.
    always_comb begin
        ext    = {{STEP{fill_i}}, data_i};
        data_o = data_i;
        for (int k = 1; k <= STEP; k++) begin
            if (n_i == STEP_W'(k)) begin
                data_o = ext[k +: XLEN];
            end
        end
    end

endmodule

// File: rtl/shift_right_serial.sv
// Multi-cycle SRL/SRA unit for the ALU execute stage. Captures an operand and a
// 5-bit shift amount, shifts by up to STEP positions per clock, then holds the
// result under a valid/ready handshake until the consumer takes it.
//
// state | meaning
// IDLE  | in_ready high, waiting for a request
// SHIFT | shifting data_q right, remaining count > 0
// DONE  | out_valid high, result held until out_ready
module shift_right_serial #(
    parameter int XLEN = 32,
    parameter int STEP = 1
)
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] in_a,
    input  logic [XLEN-1:0] in_b,
    input  logic            in_arith,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_result,
    output logic            busy
);

    import alu_pkg::*;

    if (XLEN != alu_pkg::XLEN) begin : g_bad_xlen
        $error("shift_right_serial: only XLEN = 32 is supported");
    end
    if (!step_is_legal(STEP)) begin : g_bad_step
        $error("shift_right_serial: STEP must be 1, 2, 4, 8, 16 or 32");
    end

    shr_state_t         state_q, state_d;
    logic [XLEN-1:0]    data_q,  data_d;
    logic [SHAMT_W-1:0] rem_q,   rem_d;
    alu_shift_op_t      op_q,    op_d;

    logic [STEP_W-1:0]  step_n;
    logic               fill;
    logic [XLEN-1:0]    stepped;
    logic [SHAMT_W-1:0] shamt_in;
    logic               unused_in_b_hi;

    // Only the low five bits of in_b form the shift amount.
    assign shamt_in       = in_b[SHAMT_W-1:0];
    assign unused_in_b_hi = ^in_b[XLEN-1:SHAMT_W];

    // The sign bit stays in data_q[31] throughout an SRA because every step
    // replicates it, so the captured sign need not be stored separately.
    assign step_n = shr_step_amount(rem_q, STEP);
    assign fill   = (op_q == SHIFT_OP_SRA) & data_q[XLEN-1];

    shr_step #(
        .STEP   (STEP)
    ) u_step (
        .data_i (data_q),
        .n_i    (step_n),
        .fill_i (fill),
        .data_o (stepped)
    );

    // Next-state and datapath update for the capture / shift / hold sequence.
    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        rem_d   = rem_q;
        op_d    = op_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    data_d  = in_a;
                    rem_d   = shamt_in;
                    op_d    = alu_shift_op_t'(in_arith);
                    state_d = (shamt_in != '0) ? SHIFT : DONE;
                end
            end
            SHIFT: begin
                data_d = stepped;
                rem_d  = rem_q - step_n[SHAMT_W-1:0];
                if ({1'b0, rem_q} == step_n) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset aborts any operation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            data_q  <= '0;
            rem_q   <= '0;
            op_q    <= SHIFT_OP_SRL;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            rem_q   <= rem_d;
            op_q    <= op_d;
        end
    end

    assign in_ready   = (state_q == IDLE);
    assign out_valid  = (state_q == DONE);
    assign busy       = (state_q != IDLE);
    assign out_result = data_q;

endmodule

// File: tb/tb_shift_right_serial.sv
// Bench for shift_right_serial: one instance with STEP = 1 and one with STEP = 4.
// Stimulus pushes hand-computed results into a per-instance queue; a monitor per
// instance pops and checks whenever the DUT presents out_valid.
module tb_shift_right_serial;

    typedef struct {
        logic [31:0] result;
        int          lat;
        int          hold;
        int          acc_cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    for (genvar g = 0; g < 2; g++) begin : g_dut
        localparam int STEP_G = (g == 0) ? 1 : 4;

        logic        in_valid = 1'b0;
        logic        in_arith = 1'b0;
        logic        out_ready = 1'b0;
        logic [31:0] in_a = '0;
        logic [31:0] in_b = '0;
        logic        in_ready, out_valid, busy;
        logic [31:0] out_result;

        exp_t        q[$];
        exp_t        cur;
        logic        active = 1'b0;
        int          hold_left = 0;
        logic [31:0] held = '0;

        shift_right_serial #(
            .XLEN       (32),
            .STEP       (STEP_G)
        ) u_dut (
            .clk        (clk),
            .rst_n      (rst_n),
            .in_valid   (in_valid),
            .in_ready   (in_ready),
            .in_a       (in_a),
            .in_b       (in_b),
            .in_arith   (in_arith),
            .out_valid  (out_valid),
            .out_ready  (out_ready),
            .out_result (out_result),
            .busy       (busy)
        );

        // Monitor: check result and latency on first out_valid, stability under
        // backpressure, and the return to IDLE after the handshake.
        always @(negedge clk) begin
            if (!rst_n) begin
                active    = 1'b0;
                out_ready = 1'b0;
            end else if (!active) begin
                if (out_valid) begin
                    if (q.size() == 0) begin
                        check($sformatf("dut%0d_unexpected_valid", g), 32'd1, 32'd0);
                        out_ready = 1'b1;
                        active    = 1'b1;
                    end else begin
                        cur = q.pop_front();
                        check($sformatf("dut%0d_result", g), out_result, cur.result);
                        check($sformatf("dut%0d_latency", g), 32'(cyc - cur.acc_cyc + 1), 32'(cur.lat));
                        check($sformatf("dut%0d_in_ready_in_done", g), {31'b0, in_ready}, 32'd0);
                        held      = out_result;
                        hold_left = cur.hold;
                        active    = 1'b1;
                        if (hold_left == 0) out_ready = 1'b1;
                    end
                end else if (q.size() != 0 && (cyc - q[0].acc_cyc) > 200) begin
                    check($sformatf("dut%0d_valid_timeout", g), 32'd0, 32'd1);
                    void'(q.pop_front());
                end
            end else if (out_ready) begin
                check($sformatf("dut%0d_out_valid_after_hs", g), {31'b0, out_valid}, 32'd0);
                check($sformatf("dut%0d_in_ready_after_hs", g), {31'b0, in_ready}, 32'd1);
                check($sformatf("dut%0d_busy_after_hs", g), {31'b0, busy}, 32'd0);
                out_ready = 1'b0;
                active    = 1'b0;
            end else begin
                check($sformatf("dut%0d_hold_valid", g), {31'b0, out_valid}, 32'd1);
                check($sformatf("dut%0d_hold_result", g), out_result, held);
                check($sformatf("dut%0d_hold_in_ready", g), {31'b0, in_ready}, 32'd0);
                hold_left--;
                if (hold_left <= 0) out_ready = 1'b1;
            end
        end
    end

    task automatic drive(input int d, input logic v, input logic [31:0] a,
                         input logic [31:0] b, input logic ar);
        if (d == 0) begin
            g_dut[0].in_valid = v; g_dut[0].in_a = a; g_dut[0].in_b = b; g_dut[0].in_arith = ar;
        end else begin
            g_dut[1].in_valid = v; g_dut[1].in_a = a; g_dut[1].in_b = b; g_dut[1].in_arith = ar;
        end
    endtask

    function automatic logic rdy(input int d);
        return (d == 0) ? g_dut[0].in_ready : g_dut[1].in_ready;
    endfunction

    // Issue one request; the expected result is queued before the accepting edge.
    task automatic issue(input int d, input logic [31:0] a, input logic [31:0] b,
                         input logic ar, input logic [31:0] res, input int lat,
                         input int hold, input bit push);
        exp_t e;
        int   t;
        t = 0;
        @(negedge clk);
        while (!rdy(d) && t < 300) begin
            @(negedge clk);
            t++;
        end
        if (!rdy(d)) begin
            check($sformatf("dut%0d_in_ready_timeout", d), 32'd0, 32'd1);
            return;
        end
        if (push) begin
            e.result  = res;
            e.lat     = lat;
            e.hold    = hold;
            e.acc_cyc = cyc + 1;
            if (d == 0) g_dut[0].q.push_back(e);
            else        g_dut[1].q.push_back(e);
        end
        drive(d, 1'b1, a, b, ar);
        @(negedge clk);
        // Scramble the operands after capture; they must have no effect.
        drive(d, 1'b0, 32'hFFFF_FFFF, 32'h0000_001F, ~ar);
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        while ((g_dut[0].q.size() != 0 || g_dut[0].active ||
                g_dut[1].q.size() != 0 || g_dut[1].active) && t < 1000) begin
            @(negedge clk);
            t++;
        end
        if (t >= 1000) check("drain_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        #1 rst_n = 1'b0;
        #2;
        check("rst_in_ready0",   {31'b0, g_dut[0].in_ready},  32'd1);
        check("rst_out_valid0",  {31'b0, g_dut[0].out_valid}, 32'd0);
        check("rst_busy0",       {31'b0, g_dut[0].busy},      32'd0);
        check("rst_out_result0", g_dut[0].out_result,         32'd0);
        check("rst_in_ready1",   {31'b0, g_dut[1].in_ready},  32'd1);
        check("rst_out_result1", g_dut[1].out_result,         32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        fork
            begin
                issue(0, 32'h8000_0000, 32'd31,        1'b0, 32'h0000_0001, 32, 0,  1);
                issue(0, 32'h8000_0000, 32'd4,         1'b1, 32'hF800_0000, 5,  0,  1);
                issue(0, 32'h8000_0000, 32'd4,         1'b0, 32'h0800_0000, 5,  0,  1);
                issue(0, 32'h0000_00F0, 32'h0000_0024, 1'b0, 32'h0000_000F, 5,  0,  1);
                issue(0, 32'h0000_00F0, 32'h0000_0020, 1'b0, 32'h0000_00F0, 1,  0,  1);
                issue(0, 32'h8765_4321, 32'd8,         1'b1, 32'hFF87_6543, 9,  10, 1);
                issue(0, 32'h8765_4321, 32'd1,         1'b0, 32'h43B2_A190, 2,  0,  1);
            end
            begin
                issue(1, 32'hFFFF_FF00, 32'd7,         1'b1, 32'hFFFF_FFFE, 3,  3,  1);
                issue(1, 32'h8000_0000, 32'd31,        1'b0, 32'h0000_0001, 9,  0,  1);
                issue(1, 32'h8000_0000, 32'd0,         1'b1, 32'h8000_0000, 1,  0,  1);
                issue(1, 32'hFFFF_FFFF, 32'd5,         1'b0, 32'h07FF_FFFF, 3,  0,  1);
                issue(1, 32'h7FFF_FFFF, 32'd16,        1'b1, 32'h0000_7FFF, 5,  0,  1);
            end
        join
        wait_idle();

        // Abort a 20-position shift partway through.
        issue(0, 32'hA5A5_A5A5, 32'd20, 1'b0, 32'd0, 0, 0, 0);
        repeat (4) @(negedge clk);
        check("mid_shift_busy", {31'b0, g_dut[0].busy}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("abort_out_valid",  {31'b0, g_dut[0].out_valid}, 32'd0);
        check("abort_out_result", g_dut[0].out_result,         32'd0);
        check("abort_busy",       {31'b0, g_dut[0].busy},      32'd0);
        check("abort_in_ready",   {31'b0, g_dut[0].in_ready},  32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        issue(0, 32'h1234_5678, 32'd8, 1'b0, 32'h0012_3456, 9, 0, 1);
        wait_idle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
